// File: rtl/mvm_pkg.sv
// Shared constants for the MVM AXIS traffic generator.
// Holds tuser field layout, opcode values and the sequencer state encoding.
package mvm_pkg;

  localparam int RF_LSB  = 0;
  localparam int OP_LSB  = 9;

  localparam int OP_INST = 0;
  localparam int OP_RED  = 1;
  localparam int OP_VEC  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } tg_state_e;

endpackage

// File: rtl/mvm_axis_traffic_gen_monitor.sv
// Response side of the traffic generator: always-ready sink that
// counts axis_tx beats and keeps the most recent beat's payload.
module axis_beat_monitor
  import mvm_pkg::*;
#(
  parameter int DATAW = 512,
  parameter int USERW = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             mon_tvalid,
  input  logic [DATAW-1:0] mon_tdata,
  input  logic [USERW-1:0] mon_tuser,
  output logic             mon_tready,
  output logic             o_beat,
  output logic [15:0]      rsp_count,
  output logic [DATAW-1:0] rsp_last_data,
  output logic [USERW-1:0] rsp_last_user
);

  logic             r_rdy;
  logic [15:0]      r_cnt;
  logic [DATAW-1:0] r_data;
  logic [USERW-1:0] r_user;

  assign mon_tready    = r_rdy;
  assign o_beat        = mon_tvalid & r_rdy;
  assign rsp_count     = r_cnt;
  assign rsp_last_data = r_data;
  assign rsp_last_user = r_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy  <= 1'b0;
      r_cnt  <= '0;
      r_data <= '0;
      r_user <= '0;
    end else begin
      r_rdy <= 1'b1;
      // a beat coinciding with a new run counts toward that run
      if (i_clr)
        r_cnt <= o_beat ? 16'd1 : 16'd0;
      else if (o_beat && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
      if (o_beat) begin
        r_data <= mon_tdata;
        r_user <= mon_tuser;
      end
    end
  end

endmodule

// File: rtl/mvm_axis_traffic_gen.sv
// Replays a programmable table of single-beat packets into MVM axis_rx
// and watches axis_tx for the expected number of responses.
module mvm_axis_traffic_gen
  import mvm_pkg::*;
#(
  parameter int DATAW     = 512,
  parameter int DESTW     = 12,
  parameter int USERW     = 75,
  parameter int RFADDRW   = 9,
  parameter int AXIS_OPS  = 4,
  parameter int AXIS_OPSW = $clog2(AXIS_OPS),
  parameter int SEQD      = 16,
  parameter int SEQADDRW  = $clog2(SEQD),
  parameter int GAPW      = 8,
  parameter int TOW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [SEQADDRW-1:0]  cfg_idx,
  input  logic [AXIS_OPSW-1:0] cfg_op,
  input  logic [RFADDRW-1:0]   cfg_rfaddr,
  input  logic [7:0]           cfg_fill,
  input  logic [DESTW-1:0]     cfg_dest,
  input  logic                 start,
  input  logic [SEQADDRW:0]    num_pkts,
  input  logic [GAPW-1:0]      gap,
  input  logic [15:0]          exp_rsp,
  input  logic [TOW-1:0]       timeout,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [15:0]          rsp_count,
  output logic [DATAW-1:0]     rsp_last_data,
  output logic [USERW-1:0]     rsp_last_user,
  output logic                 gen_tvalid,
  output logic [DATAW-1:0]     gen_tdata,
  output logic [USERW-1:0]     gen_tuser,
  output logic [DESTW-1:0]     gen_tdest,
  output logic                 gen_tlast,
  input  logic                 gen_tready,
  input  logic                 mon_tvalid,
  input  logic [DATAW-1:0]     mon_tdata,
  input  logic [USERW-1:0]     mon_tuser,
  input  logic                 mon_tlast,
  output logic                 mon_tready
);

  localparam int OPL = RF_LSB + RFADDRW;
  localparam int CW  = SEQADDRW + 1;

  logic [AXIS_OPSW-1:0] r_op   [SEQD];
  logic [RFADDRW-1:0]   r_rf   [SEQD];
  logic [7:0]           r_fill [SEQD];
  logic [DESTW-1:0]     r_dst  [SEQD];

  tg_state_e            r_st;
  logic                 r_tvalid;
  logic [DATAW-1:0]     r_tdata;
  logic [USERW-1:0]     r_tuser;
  logic [DESTW-1:0]     r_tdest;
  logic                 r_tlast;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [SEQADDRW-1:0]  r_idx;
  logic [CW-1:0]        r_num;
  logic [GAPW-1:0]      r_gap;
  logic [GAPW-1:0]      r_gcnt;
  logic [15:0]          r_exp;
  logic [TOW-1:0]       r_to;
  logic [TOW-1:0]       r_tcnt;

  logic                 w_clr;
  logic                 w_beat;
  logic                 w_last;
  logic [SEQADDRW-1:0]  w_nidx;
  logic                 w_mon_tlast;

  assign gen_tvalid  = r_tvalid;
  assign gen_tdata   = r_tdata;
  assign gen_tuser   = r_tuser;
  assign gen_tdest   = r_tdest;
  assign gen_tlast   = r_tlast;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_err;

  // every response is a single beat, so tlast carries no extra framing
  assign w_mon_tlast = mon_tlast;

  assign w_clr  = (r_st == S_IDLE) && start;
  assign w_nidx = r_idx + SEQADDRW'(1);
  assign w_last = (r_num == '0) ||
                  (({1'b0, r_idx} + CW'(1)) == r_num);

  function automatic logic [USERW-1:0] f_user(
    input logic [AXIS_OPSW-1:0] op,
    input logic [RFADDRW-1:0]   rf
  );
    f_user = '0;
    f_user[RF_LSB +: RFADDRW] = rf;
    f_user[OPL +: AXIS_OPSW]  = op;
  endfunction

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      r_op[cfg_idx]   <= cfg_op;
      r_rf[cfg_idx]   <= cfg_rfaddr;
      r_fill[cfg_idx] <= cfg_fill;
      r_dst[cfg_idx]  <= cfg_dest;
    end
  end

  axis_beat_monitor #(
    .DATAW(DATAW),
    .USERW(USERW)
  ) u_mon (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .mon_tvalid   (mon_tvalid),
    .mon_tdata    (mon_tdata),
    .mon_tuser    (mon_tuser),
    .mon_tready   (mon_tready),
    .o_beat       (w_beat),
    .rsp_count    (rsp_count),
    .rsp_last_data(rsp_last_data),
    .rsp_last_user(rsp_last_user)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= S_IDLE;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tdest  <= '0;
      r_tlast  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_num    <= '0;
      r_gap    <= '0;
      r_gcnt   <= '0;
      r_exp    <= '0;
      r_to     <= '0;
      r_tcnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (start) begin
            r_num    <= num_pkts;
            r_gap    <= gap;
            r_exp    <= exp_rsp;
            r_to     <= timeout;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_idx    <= '0;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_tdata  <= {(DATAW/8){r_fill[0]}};
            r_tuser  <= f_user(r_op[0], r_rf[0]);
            r_tdest  <= r_dst[0];
            r_st     <= S_SEND;
          end
        end
        S_SEND: begin
          if (gen_tready) begin
            if (w_last) begin
              r_tvalid <= 1'b0;
              r_tcnt   <= '0;
              r_st     <= S_WAIT;
            end else if (r_gap == '0) begin
              r_idx   <= w_nidx;
              r_tdata <= {(DATAW/8){r_fill[w_nidx]}};
              r_tuser <= f_user(r_op[w_nidx], r_rf[w_nidx]);
              r_tdest <= r_dst[w_nidx];
            end else begin
              r_idx    <= w_nidx;
              r_tvalid <= 1'b0;
              r_gcnt   <= r_gap;
              r_st     <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // payload is read at the end of the gap so late table writes apply
          if (r_gcnt <= GAPW'(1)) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {(DATAW/8){r_fill[r_idx]}};
            r_tuser  <= f_user(r_op[r_idx], r_rf[r_idx]);
            r_tdest  <= r_dst[r_idx];
            r_st     <= S_SEND;
          end else begin
            r_gcnt <= r_gcnt - GAPW'(1);
          end
        end
        S_WAIT: begin
          if (rsp_count >= r_exp) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_st   <= S_DONE;
          end else if (w_beat) begin
            r_tcnt <= '0;
          end else if (r_to != '0 &&
                       (r_tcnt + TOW'(1)) == r_to) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_err  <= 1'b1;
            r_st   <= S_DONE;
          end else if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + TOW'(1);
          end
        end
        S_DONE: begin
          r_st <= S_IDLE;
        end
        default: begin
          r_st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_axis_traffic_gen.sv
// Directed bench for mvm_axis_traffic_gen: sequencing, gaps,
// backpressure, response capture, timeout and mid-run reset.
module tb_mvm_axis_traffic_gen;

  localparam int DATAW   = 512;
  localparam int DESTW   = 12;
  localparam int USERW   = 75;
  localparam int RFADDRW = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [3:0]       cfg_idx;
  logic [1:0]       cfg_op;
  logic [8:0]       cfg_rfaddr;
  logic [7:0]       cfg_fill;
  logic [DESTW-1:0] cfg_dest;
  logic             start;
  logic [4:0]       num_pkts;
  logic [7:0]       gap;
  logic [15:0]      exp_rsp;
  logic [15:0]      timeout;
  logic             busy, done, timeout_err;
  logic [15:0]      rsp_count;
  logic [DATAW-1:0] rsp_last_data;
  logic [USERW-1:0] rsp_last_user;
  logic             gen_tvalid, gen_tlast, gen_tready;
  logic [DATAW-1:0] gen_tdata;
  logic [USERW-1:0] gen_tuser;
  logic [DESTW-1:0] gen_tdest;
  logic             mon_tvalid, mon_tlast, mon_tready;
  logic [DATAW-1:0] mon_tdata;
  logic [USERW-1:0] mon_tuser;

  always #5 clk = ~clk;

  mvm_axis_traffic_gen dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_op(cfg_op),
    .cfg_rfaddr(cfg_rfaddr), .cfg_fill(cfg_fill), .cfg_dest(cfg_dest),
    .start(start), .num_pkts(num_pkts), .gap(gap),
    .exp_rsp(exp_rsp), .timeout(timeout),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .rsp_count(rsp_count), .rsp_last_data(rsp_last_data),
    .rsp_last_user(rsp_last_user),
    .gen_tvalid(gen_tvalid), .gen_tdata(gen_tdata),
    .gen_tuser(gen_tuser), .gen_tdest(gen_tdest),
    .gen_tlast(gen_tlast), .gen_tready(gen_tready),
    .mon_tvalid(mon_tvalid), .mon_tdata(mon_tdata),
    .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
    .mon_tready(mon_tready)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_n = 0;
  int stall_bad = 0;

  int               bcyc[$];
  logic [USERW-1:0] buser[$];
  logic [DATAW-1:0] bdata[$];
  logic [DESTW-1:0] bdest[$];

  logic [1:0]       t_op[16];
  logic [8:0]       t_rf[16];
  logic [7:0]       t_fill[16];
  logic [DESTW-1:0] t_dest[16];

  function automatic logic [DATAW-1:0] rep(input logic [7:0] f);
    logic [DATAW-1:0] d;
    for (int k = 0; k < DATAW/8; k++) d[k*8 +: 8] = f;
    return d;
  endfunction

  function automatic logic [USERW-1:0] eu(input int i);
    logic [USERW-1:0] u;
    u = '0;
    u[RFADDRW-1:0] = t_rf[i];
    u[RFADDRW +: 2] = t_op[i];
    return u;
  endfunction

  task automatic chk(input string tag, input logic [DATAW-1:0] got,
                     input logic [DATAW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (gen_tvalid === 1'b1 && gen_tready === 1'b1) begin
      bcyc.push_back(cyc);
      buser.push_back(gen_tuser);
      bdata.push_back(gen_tdata);
      bdest.push_back(gen_tdest);
    end
    if (gen_tvalid === 1'b1 && gen_tready === 1'b0) begin
      stall_n++;
      if (gen_tuser !== eu(1) || gen_tdata !== rep(t_fill[1]))
        stall_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input int op, input int rf,
                    input int fill, input int dest);
    t_op[i] = 2'(op);
    t_rf[i] = 9'(rf);
    t_fill[i] = 8'(fill);
    t_dest[i] = DESTW'(dest);
    cfg_we = 1'b1;
    cfg_idx = 4'(i);
    cfg_op = 2'(op);
    cfg_rfaddr = 9'(rf);
    cfg_fill = 8'(fill);
    cfg_dest = DESTW'(dest);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int n, input int g, input int e, input int to);
    bcyc.delete();
    buser.delete();
    bdata.delete();
    bdest.delete();
    stall_n = 0;
    stall_bad = 0;
    num_pkts = 5'(n);
    gap = 8'(g);
    exp_rsp = 16'(e);
    timeout = 16'(to);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) tick();
    chk(tag, DATAW'(done_cnt - d0), DATAW'(1));
  endtask

  task automatic wait_beats(input int n, input int bound);
    for (int i = 0; i < bound && bcyc.size() < n; i++) tick();
  endtask

  int c0;
  int rsp_cyc;
  int bad;
  int d_before;
  logic [DATAW-1:0] pat;

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_op = '0; cfg_rfaddr = '0;
    cfg_fill = '0; cfg_dest = '0;
    start = 1'b0; num_pkts = '0; gap = '0; exp_rsp = '0; timeout = '0;
    gen_tready = 1'b1;
    mon_tvalid = 1'b0; mon_tdata = '0; mon_tuser = '0; mon_tlast = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", DATAW'(gen_tvalid), DATAW'(0));
    chk("rst_busy", DATAW'(busy), DATAW'(0));
    chk("rst_done", DATAW'(done), DATAW'(0));
    chk("rst_tmo", DATAW'(timeout_err), DATAW'(0));
    chk("rst_count", DATAW'(rsp_count), DATAW'(0));
    chk("rst_tdata", gen_tdata, DATAW'(0));
    chk("rst_tuser", DATAW'(gen_tuser), DATAW'(0));
    chk("rst_tlast", DATAW'(gen_tlast), DATAW'(0));
    chk("rst_mready", DATAW'(mon_tready), DATAW'(0));
    rst = 1'b0;
    tick();
    chk("mready_up", DATAW'(mon_tready), DATAW'(1));

    wr(0, 0, 0, 8'h00, 0);
    wr(1, 2, 0, 8'h01, 1);
    wr(2, 1, 0, 8'h02, 2);
    for (int i = 3; i < 16; i++) wr(i, i % 4, i * 3, 8'h10 + i, 100 + i);

    // three packets with one idle cycle between them
    c0 = cyc;
    run(3, 1, 0, 0);
    wait_done("t1_done", 40);
    chk("t1_nbeats", DATAW'(bcyc.size()), DATAW'(3));
    if (bcyc.size() == 3) begin
      chk("t1_lat", DATAW'(bcyc[0] - c0), DATAW'(1));
      chk("t1_op0", DATAW'(buser[0][10:9]), DATAW'(0));
      chk("t1_op1", DATAW'(buser[1][10:9]), DATAW'(2));
      chk("t1_data1", bdata[1], rep(8'h01));
      chk("t1_op2", DATAW'(buser[2][10:9]), DATAW'(1));
      chk("t1_data2", bdata[2], rep(8'h02));
      chk("t1_gap01", DATAW'(bcyc[1] - bcyc[0]), DATAW'(2));
      chk("t1_gap12", DATAW'(bcyc[2] - bcyc[1]), DATAW'(2));
    end
    chk("t1_pulse", DATAW'(done), DATAW'(0));
    chk("t1_busy", DATAW'(busy), DATAW'(0));

    // backpressure: packet 1 held for five cycles
    run(3, 0, 0, 0);
    wait_beats(1, 20);
    gen_tready = 1'b0;
    repeat (5) tick();
    gen_tready = 1'b1;
    wait_done("t2_done", 40);
    chk("t2_stalls", DATAW'(stall_n), DATAW'(5));
    chk("t2_stable", DATAW'(stall_bad), DATAW'(0));
    chk("t2_nbeats", DATAW'(bcyc.size()), DATAW'(3));
    if (bcyc.size() == 3) begin
      chk("t2_u0", DATAW'(buser[0]), DATAW'(eu(0)));
      chk("t2_u1", DATAW'(buser[1]), DATAW'(eu(1)));
      chk("t2_u2", DATAW'(buser[2]), DATAW'(eu(2)));
    end

    // one expected response arriving late
    run(1, 0, 1, 0);
    wait_beats(1, 20);
    repeat (20) tick();
    pat = {16{32'hDEAD_BEEF}};
    mon_tvalid = 1'b1;
    mon_tdata = pat;
    mon_tuser = 75'h123;
    mon_tlast = 1'b1;
    tick();
    mon_tvalid = 1'b0;
    wait_done("t3_done", 20);
    chk("t3_count", DATAW'(rsp_count), DATAW'(1));
    chk("t3_data", rsp_last_data, pat);
    chk("t3_user", DATAW'(rsp_last_user), DATAW'(75'h123));
    chk("t3_tmo", DATAW'(timeout_err), DATAW'(0));

    // two expected, one arrives: done 50 cycles after that beat
    run(1, 0, 2, 50);
    wait_beats(1, 20);
    repeat (5) tick();
    mon_tvalid = 1'b1;
    mon_tdata = rep(8'h77);
    rsp_cyc = cyc + 1;
    tick();
    mon_tvalid = 1'b0;
    wait_done("t4_done", 100);
    chk("t4_when", DATAW'(done_cyc - rsp_cyc), DATAW'(50));
    chk("t4_tmo", DATAW'(timeout_err), DATAW'(1));
    chk("t4_count", DATAW'(rsp_count), DATAW'(1));

    // full table back to back; a second start mid-run is ignored
    run(16, 0, 0, 0);
    chk("t5_tmo_clr", DATAW'(timeout_err), DATAW'(0));
    chk("t5_cnt_clr", DATAW'(rsp_count), DATAW'(0));
    chk("t5_busy", DATAW'(busy), DATAW'(1));
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done", 60);
    chk("t5_nbeats", DATAW'(bcyc.size()), DATAW'(16));
    if (bcyc.size() == 16) begin
      chk("t5_span", DATAW'(bcyc[15] - bcyc[0]), DATAW'(15));
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (bdata[i] !== rep(t_fill[i]) || bdest[i] !== t_dest[i]) bad++;
      chk("t5_payload", DATAW'(bad), DATAW'(0));
      chk("t5_u15", DATAW'(buser[15]), DATAW'(eu(15)));
    end
    repeat (3) tick();
    chk("t5_no_rerun", DATAW'(gen_tvalid), DATAW'(0));

    // reset while in a gap, then a clean run from entry 0
    wr(0, 3, 7, 8'hA5, 9);
    run(3, 5, 0, 0);
    wait_beats(1, 20);
    tick();
    d_before = done_cnt;
    rst = 1'b1;
    tick();
    chk("t6_tvalid", DATAW'(gen_tvalid), DATAW'(0));
    chk("t6_busy", DATAW'(busy), DATAW'(0));
    chk("t6_tdata", gen_tdata, DATAW'(0));
    chk("t6_tuser", DATAW'(gen_tuser), DATAW'(0));
    chk("t6_mready", DATAW'(mon_tready), DATAW'(0));
    rst = 1'b0;
    repeat (10) tick();
    chk("t6_nodone", DATAW'(done_cnt - d_before), DATAW'(0));
    run(1, 0, 0, 0);
    wait_done("t6_done", 20);
    chk("t6_nbeats", DATAW'(bcyc.size()), DATAW'(1));
    if (bcyc.size() == 1) begin
      chk("t6_u0", DATAW'(buser[0]), DATAW'(eu(0)));
      chk("t6_d0", bdata[0], rep(8'hA5));
      chk("t6_dest0", DATAW'(bdest[0]), DATAW'(9));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_axis_traffic_gen.md
# mvm_axis_traffic_gen

Synthesizable AXI-Stream stimulus sequencer and response monitor for the MVM tile. It replays a programmable table of single-beat packets (instruction, reduction vector, input vector, or any `AXIS_OPS` opcode) into the MVM `axis_rx` port, honouring backpressure and a configurable inter-packet gap. It counts and captures `axis_tx` responses, and flags a timeout, so the MVM can be exercised on-chip or in regression without a hand-written bench.

## Interface
- `DATAW`, default 512: AXIS data width.
- `DESTW`, default 12: tdest width.
- `USERW`, default 75: tuser width; must be ≥ `RFADDRW`+`AXIS_OPSW`.
- `RFADDRW`, default 9: register-file address field, tuser[`RFADDRW`-1:0].
- `AXIS_OPS`, default 4: opcode count.
- `AXIS_OPSW`, default $clog2(`AXIS_OPS`): opcode field, tuser[`RFADDRW`+:`AXIS_OPSW`].
- `SEQD`, default 16: sequence table depth.
- `SEQADDRW`, default $clog2(`SEQD`): table index width.
- `GAPW`, default 8: inter-packet gap counter width.
- `TOW`, default 16: response timeout counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: write table entry.
- `cfg_idx` in `SEQADDRW`: entry index.
- `cfg_op` in `AXIS_OPSW`: entry opcode.
- `cfg_rfaddr` in `RFADDRW`: entry RF address.
- `cfg_fill` in 8: byte replicated across tdata.
- `cfg_dest` in `DESTW`: entry tdest.
- `start` in 1: launch a run; sampled only in IDLE.
- `num_pkts` in `SEQADDRW`+1: entries to send, 1..`SEQD`; sampled at start.
- `gap` in `GAPW`: idle cycles between packets; sampled at start.
- `exp_rsp` in 16: responses expected; sampled at start.
- `timeout` in `TOW`: idle-cycle limit while waiting; sampled at start.
- `busy` out 1; `done` out 1 (one-cycle pulse); `timeout_err` out 1 (sticky until next start or rst).
- `rsp_count` out 16; `rsp_last_data` out `DATAW`; `rsp_last_user` out `USERW`.
- `gen_tvalid` out 1, `gen_tdata` out `DATAW`, `gen_tuser` out `USERW`, `gen_tdest` out `DESTW`, `gen_tlast` out 1, `gen_tready` in 1: master, drives MVM `axis_rx`.
- `mon_tvalid` in 1, `mon_tdata` in `DATAW`, `mon_tuser` in `USERW`, `mon_tlast` in 1, `mon_tready` out 1: slave, fed from MVM `axis_tx`.

## Operation
- Table is a `SEQD`-entry register array. Writes are accepted in any state, but a write landing on the entry currently being driven takes effect only from the next packet.
- Packet formation:
  - tdata = {DATAW/8{fill}}.
  - tuser = rfaddr in the low field, op in the next field, remaining bits 0.
  - tlast = 1 on every beat; tdest = entry dest.
- FSM states:
  - IDLE → SEND on `start`.
  - SEND: `gen_tvalid`=1, payload held stable until `gen_tvalid`&`gen_tready`. On handshake, if it was the last packet → WAIT; else if gap=0 → SEND with the next index; else → GAP.
  - GAP: counts `gap` cycles with `gen_tvalid`=0, then → SEND.
  - WAIT: exits when `rsp_count`≥`exp_rsp` → DONE. If the timeout counter reaches `timeout` → DONE with `timeout_err`=1.
  - DONE: pulses `done` for one cycle → IDLE.
- Monitor:
  - `mon_tready`=1 whenever not in reset, in every state.
  - Each `mon_tvalid` beat increments `rsp_count` (saturating at 0xFFFF) and captures data and user.
  - Responses arriving during SEND or GAP are counted.
  - `rsp_count` clears at `start`.
- Timeout counter runs only in WAIT. It resets on every accepted response and saturates.
- `exp_rsp`=0 means WAIT exits on its first cycle.
- `timeout`=0 disables the timeout.
- `start` while busy is ignored.

## Timing
- Reset values:
  - `gen_tvalid`=0, `gen_tdata`/`gen_tuser`/`gen_tdest`=0, `gen_tlast`=0.
  - `busy`=0, `done`=0, `timeout_err`=0, `rsp_count`=0, `rsp_last_*`=0, `mon_tready`=0.
  - FSM = IDLE; table contents are not reset.
- `start` at cycle t → `gen_tvalid`=1 with entry 0 at t+1; `busy`=1 from t+1 until DONE.
- With gap=0 and `gen_tready` held at 1, the run is back-to-back, one packet per cycle.
- With gap=g, the next `gen_tvalid` rises g+1 cycles after the handshake.
- Monitor capture and count update happen one cycle after the beat.
- `rst` mid-run aborts immediately: `gen_tvalid` drops the next cycle and no `done` pulse is issued.

## Structure
- Package `mvm_pkg`: tuser field offsets (`RF_LSB`, `OP_LSB`), opcode constants (`OP_INST`=0, `OP_RED`=1, `OP_VEC`=2), FSM state enum.
- One sub-module, `axis_beat_monitor`: response counter, capture registers and `mon_tready`.

## Test plan
- Program the three entries {op0,rf0,fill 00}, {op2,rf0,fill 01}, {op1,rf0,fill 02}; gap=1, `gen_tready`=1 → three beats:
  - beat 0: tuser[10:9]=0;
  - beat 1: tuser[10:9]=2, tdata all 0x01;
  - beat 2: tuser[10:9]=1, tdata all 0x02;
  - each beat separated by one idle cycle.
- Hold `gen_tready` low for 5 cycles on packet 1 → payload stable throughout, no skipped or duplicated packet.
- `exp_rsp`=1 with a response injected 20 cycles after the last send → `done` pulses, `rsp_count`=1, `rsp_last_data` matches the injected beat.
- `exp_rsp`=2, one response only, `timeout`=50 → `done` pulses 50 cycles after the last activity, `timeout_err`=1.
- `num_pkts`=16, gap=0, ready always high → 16 consecutive valid cycles, index wraps to 0 without overrun.
- Assert `rst` during GAP → next cycle all outputs at reset values; a subsequent `start` runs cleanly from entry 0.
